// File: rtl/memory_column_pkg.sv
// Shared constants and the burst FSM state type for the memory column
// burst controller.
package memory_column_pkg;
  localparam int COL_DATA_W = 8;
  localparam int COL_ADDR_W = 10;
  localparam int COL_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } burst_state_e;
endpackage

// File: rtl/memory_column_burst_ctrl_if.sv
// Client-side bus of the burst controller: request, write-beat and
// read-beat streams. The controller uses the slave modport, the client
// the master modport.
interface memory_column_burst_ctrl_if
  import memory_column_pkg::*;
#(
  parameter int DATA_W = COL_DATA_W,
  parameter int ADDR_W = COL_ADDR_W,
  parameter int LEN_W  = COL_LEN_W
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LEN_W-1:0]  req_len_i;
  logic              wdata_valid_i;
  logic              wdata_ready_o;
  logic [DATA_W-1:0] wdata_i;
  logic              rdata_valid_o;
  logic              rdata_ready_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_last_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_len_i,
    input  wdata_valid_i, wdata_i, rdata_ready_i,
    output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_len_i,
    output wdata_valid_i, wdata_i, rdata_ready_i,
    input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o
  );
endinterface

// File: rtl/memory_column_burst_ctrl_skid.sv
// Two-entry valid/ready buffer for read beats. The producer never pushes
// into a full buffer (the controller only issues reads when there is
// room), so pushes are accepted unconditionally.
module mcb_skid_buffer #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; contents are discarded on reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_valid) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_valid} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: an entry is only visible once written.
  always_ff @(posedge clk_i) begin
    if (i_valid) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/memory_column_burst_ctrl.sv
// Burst access controller in front of the 1024x8 single-port memory column.
// Writes pass straight through to the column; reads are issued only while
// the 2-entry skid buffer can absorb every outstanding beat.
// Optional: MEMORY_COLUMN_BOUNDARY_CHECK_EN rejects bursts that would run
// past the top address (err_o pulse) instead of wrapping.
module memory_column_burst_ctrl
  import memory_column_pkg::*;
#(
  parameter int DATA_W = COL_DATA_W,
  parameter int ADDR_W = COL_ADDR_W,
  parameter int LEN_W  = COL_LEN_W
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  memory_column_burst_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                mem_en_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);
  burst_state_e      r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              w_hs, w_oob, w_issue, w_advance, w_room, w_last_beat;
  logic              w_buf_valid, w_buf_last;
  logic [1:0]        w_buf_count;
  logic [2:0]        w_load;

  assign w_hs        = bus.req_valid_i & (r_state == IDLE);
  assign w_last_beat = (r_cnt == r_len);

`ifdef MEMORY_COLUMN_BOUNDARY_CHECK_EN
  logic [ADDR_W:0] w_end;
  logic            r_err;
  // Carry out of start+len means the burst would cross the top address.
  assign w_end = {1'b0, bus.req_addr_i} + {{(ADDR_W+1-LEN_W){1'b0}}, bus.req_len_i};
  assign w_oob = w_end[ADDR_W];
  assign err_o = r_err;

  // Error pulse in the cycle after a rejected request handshake.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_err <= 1'b0;
    else          r_err <= w_hs & w_oob;
  end
`else
  assign w_oob = 1'b0;
  assign err_o = 1'b0;
`endif

  // Room check counts the beat leaving the buffer this cycle, so a steady
  // stream with the client ready sustains one beat per cycle.
  assign w_load = {1'b0, w_buf_count}
                - {2'b00, bus.rdata_valid_o & bus.rdata_ready_i}
                + {2'b00, r_inflight};
  assign w_room = (w_load < 3'd2);

  // Next-state and output decode.
  always_comb begin
    w_state_next      = r_state;
    w_issue           = 1'b0;
    mem_en_o          = 1'b0;
    mem_wdata_o       = '0;
    mem_addr_o        = r_addr;
    bus.wdata_ready_o = 1'b0;
    bus.req_ready_o   = (r_state == IDLE);
    busy_o            = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_hs && !w_oob) w_state_next = bus.req_write_i ? WRITE : READ;
      end
      WRITE: begin
        bus.wdata_ready_o = 1'b1;
        mem_en_o          = bus.wdata_valid_i;
        mem_wdata_o       = bus.wdata_i;
        if (bus.wdata_valid_i && w_last_beat) w_state_next = IDLE;
      end
      READ: begin
        w_issue = w_room;
        if (w_room && w_last_beat) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (!w_buf_valid && !r_inflight) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_advance = mem_en_o | w_issue;

  // State, address/beat counters and read in-flight tracking.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_len           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_beat;
      if (w_hs && !w_oob) begin
        r_addr <= bus.req_addr_i;
        r_len  <= bus.req_len_i;
        r_cnt  <= '0;
      end else if (w_advance) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  mcb_skid_buffer #(.W(DATA_W + 1)) u_skid (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .i_valid (r_inflight),
    .i_data  ({r_inflight_last, mem_rdata_i}),
    .o_valid (w_buf_valid),
    .i_ready (bus.rdata_ready_i),
    .o_data  ({w_buf_last, bus.rdata_o}),
    .o_count (w_buf_count)
  );

  assign bus.rdata_valid_o = w_buf_valid;
  assign bus.rdata_last_o  = w_buf_valid & w_buf_last;
endmodule

// File: doc/memory_column_burst_ctrl.md
Name: memory_column_burst_ctrl

Overview:
- Burst access controller that sits directly upstream of the 1024x8 memory column and drives its address, write-data and write-enable pins.
- Accepts one burst request at a time (start address, length, direction) through a valid/ready handshake.
- Generates sequential column addresses; consumes write beats or returns read beats, each stream with its own valid/ready handshake.
- Decouples client backpressure from the column's fixed single-port timing.

Parameters:
- DATA_W, 8: data beat width; matches column word width.
- ADDR_W, 10: column address width (1024 words).
- LEN_W, 4: burst length field width; burst length = req_len_i + 1 (1..16 beats).

Ports:
- clk_i  in  1  clock, all logic on rising edge
- arst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  burst request valid
- req_ready_o  out  1  controller idle, request accepted when valid&ready
- req_write_i  in  1  1 = write burst, 0 = read burst
- req_addr_i  in  ADDR_W  start address
- req_len_i  in  LEN_W  beats minus one
- wdata_valid_i  in  1  write beat valid
- wdata_ready_o  out  1  write beat accepted when valid&ready
- wdata_i  in  DATA_W  write beat data
- rdata_valid_o  out  1  read beat valid
- rdata_ready_i  in  1  client accepts read beat
- rdata_o  out  DATA_W  read beat data
- rdata_last_o  out  1  final beat of read burst, qualified by rdata_valid_o
- mem_addr_o  out  ADDR_W  to column addr
- mem_wdata_o  out  DATA_W  to column in
- mem_en_o  out  1  to column en_i (write enable)
- mem_rdata_i  in  DATA_W  from column out; valid one cycle after mem_addr_o presented
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle error pulse (optional feature only; tied 0 otherwise)

Behaviour:
- FSM states: IDLE, WRITE, READ, DRAIN. Reset (arst_ni low, asynchronous) forces:
  - state = IDLE; address counter = 0; beat counter = 0
  - mem_addr_o = 0, mem_wdata_o = 0, mem_en_o = 0
  - rdata_valid_o = 0, rdata_last_o = 0, err_o = 0, busy_o = 0, wdata_ready_o = 0
- req_ready_o = (state == IDLE), so it is 1 immediately after reset.
- On request handshake, latch addr, len and direction; next state is WRITE or READ.
- WRITE:
  - wdata_ready_o = 1.
  - Each cycle with wdata_valid_i = 1: mem_en_o = 1, mem_addr_o = current address, mem_wdata_o = wdata_i (combinational pass-through).
  - On each such beat, address and beat counters advance.
  - After beat len+1, next state is IDLE. Zero added latency; no wdata bubble penalty.
- READ:
  - mem_en_o held 0; mem_addr_o = current address.
  - A read is issued (counter advances) only when output buffer occupancy plus in-flight reads is less than 2.
  - The issued address's data is captured from mem_rdata_i on the next edge into a 2-entry skid buffer.
  - With rdata_ready_i held 1, throughput is 1 beat/cycle and first-beat latency is 2 cycles after the request handshake.
  - After the last read is issued, next state is DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight, then go to IDLE. req_ready_o stays 0 until then.
- rdata_o and rdata_last_o stay stable while rdata_valid_o = 1 and rdata_ready_i = 0.
- Address arithmetic is modulo 2^ADDR_W: the address after 1023 is 0 (wrap). The beat counter is LEN_W bits.
- Writes never overlap reads; a single port is used per cycle.
- Reset mid-burst: the burst is abandoned, buffer contents are discarded, and no partial write completes after reset release.
- Simultaneous req_valid_i during a busy state is ignored (ready = 0) and must be held by the client.

Optional Feature:
- Macro: MEMORY_COLUMN_BOUNDARY_CHECK_EN.
- Defined: a request whose start + len exceeds 2^ADDR_W - 1 is still handshaked, but:
  - the FSM stays in IDLE; no memory access occurs; no wdata is consumed
  - err_o pulses high for one cycle after the handshake
- Undefined: wrap-around applies; err_o is tied to 0.

Decomposition:
- Shared package memory_column_pkg holds:
  - constants COL_DATA_W = 8 and COL_ADDR_W = 10
  - typedef enum logic [1:0] burst_state_e {IDLE, WRITE, READ, DRAIN}
- One natural sub-module: mcb_skid_buffer, a 2-entry valid/ready buffer carrying {last, data}.

Test Plan:
- Reset check: after reset release, req_ready_o = 1, busy_o = 0, mem_en_o = 0, rdata_valid_o = 0.
- Write burst addr=0x010, len=3, data 0xA1..0xA4 with wdata_valid_i high → mem_en_o high 4 consecutive cycles at addrs 0x010..0x013, then req_ready_o = 1.
- Read back addr=0x010, len=3, rdata_ready_i = 1 → rdata_o = 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles; first beat 2 cycles after handshake; rdata_last_o only on 0xA4.
- Read with rdata_ready_i toggling 1/0 every cycle → no beat lost or duplicated; data held stable while stalled; in-flight reads never exceed buffer space.
- Wrap: write addr=0x3FE, len=3, data 0x11..0x14 → writes land at 0x3FE, 0x3FF, 0x000, 0x001; the same request with MEMORY_COLUMN_BOUNDARY_CHECK_EN gives a one-cycle err_o pulse and no mem_en_o.
- Mid-burst reset: assert arst_ni low after the 2nd of 4 write beats → outputs go to reset values immediately; a subsequent read shows only the first 2 words changed.
